pollard_modexp: RTL and testbench
=================================

Name: pollard_modexp

Overview:
- Consumer of the Pollard p-1 exponent. Waits for the exponent finder's sticky `done`, captures `e`, then computes `result = base^e mod n` by left-to-right square-and-multiply.
- Its `result` feeds the downstream gcd(result-1, n) stage.
- Modular products use a bit-serial interleaved add-shift multiplier. No divider, no wide multiplier.

Parameters:
- WIDTH, 64, width of e, n, base, result and all modular arithmetic.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- e  in  WIDTH  exponent from the exponent finder; sampled only on capture.
- e_valid  in  1  exponent finder's `done`; level, sticky high.
- n  in  WIDTH  modulus; sampled on capture.
- base  in  WIDTH  Pollard base `a` (normally 2); sampled on capture.
- result  out  WIDTH  base^e mod n; valid while `done`=1.
- done  out  1  sticky high once result is valid, until reset.
- error  out  1  high with `done` when captured n == 0.

Behaviour:
- Reset values:
  - result=0, done=0, error=0.
  - FSM in IDLE, capture flag cleared.
  - Multiplier start=0.
- Capture: in IDLE with e_valid=1, latch e, n, base on that edge and go to CHECK. Capture happens at most once per reset.
- e_valid is ignored in every other state and after done, even if it drops and rises again.
- CHECK (1 cycle):
  - n==0: result=0, error=1, go to DONE.
  - n==1: result=0, go to DONE.
  - Otherwise go to REDUCE.
- REDUCE: a_r = modmul(x=1, y=base), which gives base mod n for base >= n. acc=1. Bit index i=WIDTH-1. Then go to SKIP.
- SKIP: while e[i]==0 and i>0, decrement i, one bit per cycle.
  - If e==0 (i reaches 0 with e[0]==0): result=acc=1, go to DONE.
  - Otherwise go to SQR.
- SQR: acc = modmul(acc, acc). Then go to MUL if e[i]==1, else go to NEXT.
- MUL: acc = modmul(acc, a_r). Then go to NEXT.
- NEXT (1 cycle):
  - i==0: result=acc, go to DONE.
  - Otherwise decrement i, go to SQR.
- The squaring of the leading 1 bit (acc=1) is allowed and harmless.
- DONE: done=1 and result held until reset. No re-arm.
- Modmul handshake (sub-module):
  - start is a 1-cycle pulse carrying x, y, n.
  - For j = WIDTH-1 down to 0, one bit per cycle: `p = 2p; if p>=n p-=n; if y[j] {p+=x; if p>=n p-=n}`.
  - Intermediates are WIDTH+1 bits wide to avoid overflow. Requires x<n and n>=2.
  - `ready` pulses on the cycle after the last bit, exactly WIDTH+1 cycles after start.
  - The top-level FSM waits on `ready`. start is never asserted while the multiplier is busy.
- Latency from capture edge to done rising:
  - Total = 1 (CHECK) + (WIDTH+2) (REDUCE) + skip cycles + sum over processed bits of [(WIDTH+2) + (WIDTH+2 if bit set) + 1] + 1.
  - The bench checks the exact count for e=10.
- Reset mid-operation:
  - Aborts everything: multiplier cleared, outputs return to reset values.
  - If e_valid is still high after reset releases, a fresh capture occurs.
- All arithmetic is unsigned modulo n. result < n always, except the n==0 case.

Decomposition:
- Shared package `pollard_pkg`:
  - WIDTH default.
  - FSM state enum: IDLE, CHECK, REDUCE, SKIP, SQR, MUL, NEXT, DONE.
  - Multiplier cycle-count constant MODMUL_CYCLES = WIDTH+1.
- One sub-module `mod_mul_serial`:
  - Ports: clk, reset, start, x, y, n, p, ready.
  - Reused later by the gcd stage.
- Top-level owns the FSM, bit index, acc and a_r registers.

Test Plan:
- base=2, e=10, n=1000, e_valid raised → result=24 (1024 mod 1000), done=1, error=0; latency matches the formula.
- base=100, e=1, n=7 → base reduced to 2, result=2.
- base=2, e=0, n=97 → result=1; no SQR or MUL cycles executed.
- base=2, e=64'hFFFF_FFFF_FFFF_FFFF, n=3 → result=2; also n=1 → result=0, and n=0 → result=0 with error=1.
- Pulse reset mid-SQR (base=3, e=5, n=11), e_valid held high → outputs return to 0 within 1 cycle, recapture, result=1 (243 mod 11).
- After done, toggle e_valid and change e → result and done unchanged until reset.

Source files
------------

// File: rtl/pollard_modexp_pkg.sv
// Shared definitions for the Pollard p-1 exponentiation stage.
//   DEFAULT_WIDTH : default operand width for e, n, base, result
//   state_t       : top-level sequencer states
//   MODMUL_CYCLES : cycles from a multiplier start pulse to its ready pulse
package pollard_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int MODMUL_CYCLES = DEFAULT_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        REDUCE = 3'd2,
        SKIP   = 3'd3,
        SQR    = 3'd4,
        MUL    = 3'd5,
        NEXT   = 3'd6,
        DONE   = 3'd7
    } state_t;

endpackage

// File: rtl/pollard_modexp_mod_mul_serial.sv
// Bit-serial interleaved add-shift modular multiplier: p = x*y mod n.
//   clk, reset : clock, synchronous active-high reset
//   start      : 1-cycle pulse; x, y, n are latched on that edge
//   x, y, n    : operands (x < n, n >= 2 assumed)
//   p          : product, valid while ready is high
//   ready      : 1-cycle pulse, WIDTH+1 cycles after start
// Handshake: start may only be pulsed while the unit is idle; the result is
// presented on p for the single cycle ready is high and held until the next start.
module mod_mul_serial #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] p,
    output logic             ready
);

    localparam int JW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] n_r;
    logic [JW-1:0]    j;
    logic             busy;

    // One step of the interleaved reduction. Intermediates carry one extra
    // bit so that 2p and p+x (both < 2n) never overflow.
    logic [WIDTH:0]   n_ext;
    logic [WIDTH:0]   p_dbl;
    logic [WIDTH:0]   p_red;
    logic [WIDTH:0]   p_add;
    logic [WIDTH-1:0] p_next;

    always_comb begin
        n_ext  = {1'b0, n_r};
        p_dbl  = {p, 1'b0};
        p_red  = (p_dbl >= n_ext) ? (p_dbl - n_ext) : p_dbl;
        p_add  = y_r[j] ? (p_red + {1'b0, x_r}) : p_red;
        p_next = (p_add >= n_ext) ? WIDTH'(p_add - n_ext) : WIDTH'(p_add);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_r   <= '0;
            y_r   <= '0;
            n_r   <= '0;
            p     <= '0;
            j     <= '0;
            busy  <= 1'b0;
            ready <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (start) begin
                x_r  <= x;
                y_r  <= y;
                n_r  <= n;
                p    <= '0;
                j    <= JW'(WIDTH - 1);
                busy <= 1'b1;
            end else if (busy) begin
                p <= p_next;
                if (j == '0) begin
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end else begin
                    j <= j - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pollard_modexp.sv
// Pollard p-1 modular exponentiation: result = base^e mod n, computed by
// left-to-right square-and-multiply on top of mod_mul_serial.
//   clk, reset : clock, synchronous active-high reset
//   e, e_valid : exponent and the exponent finder's sticky done (level)
//   n, base    : modulus and base, latched together with e on capture
//   result     : base^e mod n, valid while done is high
//   done       : sticky once result is valid, cleared only by reset
//   error      : raised with done when the captured modulus is zero
// Capture happens once per reset; e_valid is ignored afterwards.
module pollard_modexp
    import pollard_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] e,
    input  logic             e_valid,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] base,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             error
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic             captured;
    logic [WIDTH-1:0] e_r;
    logic [WIDTH-1:0] n_r;
    logic [WIDTH-1:0] base_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] acc;
    logic [IW-1:0]    idx;

    logic             mm_start;
    logic [WIDTH-1:0] mm_x;
    logic [WIDTH-1:0] mm_y;
    logic [WIDTH-1:0] mm_p;
    logic             mm_ready;

    mod_mul_serial #(.WIDTH(WIDTH)) u_mod_mul (
        .clk   (clk),
        .reset (reset),
        .start (mm_start),
        .x     (mm_x),
        .y     (mm_y),
        .n     (n_r),
        .p     (mm_p),
        .ready (mm_ready)
    );

    // Multiplier starts are issued on the edge that enters REDUCE/SQR/MUL, so
    // each of those states lasts exactly WIDTH+2 cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            captured <= 1'b0;
            e_r      <= '0;
            n_r      <= '0;
            base_r   <= '0;
            a_r      <= '0;
            acc      <= '0;
            idx      <= '0;
            mm_start <= 1'b0;
            mm_x     <= '0;
            mm_y     <= '0;
            result   <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            mm_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (e_valid && !captured) begin
                        e_r      <= e;
                        n_r      <= n;
                        base_r   <= base;
                        captured <= 1'b1;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (n_r == '0) begin
                        result <= '0;
                        error  <= 1'b1;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (n_r == WIDTH'(1)) begin
                        result <= '0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        // 1 * base mod n reduces a base that may be >= n.
                        mm_start <= 1'b1;
                        mm_x     <= WIDTH'(1);
                        mm_y     <= base_r;
                        acc      <= WIDTH'(1);
                        idx      <= IW'(WIDTH - 1);
                        state    <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (mm_ready) begin
                        a_r   <= mm_p;
                        state <= SKIP;
                    end
                end
                SKIP: begin
                    if (e_r[idx]) begin
                        mm_start <= 1'b1;
                        mm_x     <= acc;
                        mm_y     <= acc;
                        state    <= SQR;
                    end else if (idx == '0) begin
                        // Exponent is zero: base^0 = 1.
                        result <= acc;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                SQR: begin
                    if (mm_ready) begin
                        acc <= mm_p;
                        if (e_r[idx]) begin
                            mm_start <= 1'b1;
                            mm_x     <= mm_p;
                            mm_y     <= a_r;
                            state    <= MUL;
                        end else begin
                            state <= NEXT;
                        end
                    end
                end
                MUL: begin
                    if (mm_ready) begin
                        acc   <= mm_p;
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx == '0) begin
                        result <= acc;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx      <= idx - 1'b1;
                        mm_start <= 1'b1;
                        mm_x     <= acc;
                        mm_y     <= acc;
                        state    <= SQR;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pollard_modexp.sv
// Directed bench for pollard_modexp (WIDTH = 64).
module tb_pollard_modexp;

    localparam int W = 64;

    logic         clk;
    logic         reset;
    logic [W-1:0] e;
    logic         e_valid;
    logic [W-1:0] n;
    logic [W-1:0] base;
    logic [W-1:0] result;
    logic         done;
    logic         error;

    int checks;
    int failures;
    int lat;

    pollard_modexp #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .e       (e),
        .e_valid (e_valid),
        .n       (n),
        .base    (base),
        .result  (result),
        .done    (done),
        .error   (error)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset   = 1'b1;
        e_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Counts edges after the capture edge until done is seen (bounded).
    task automatic wait_done(input int max_cycles, output int cycles);
        cycles = 0;
        while (cycles <= max_cycles) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) break;
        end
    endtask

    // Drive operands and raise e_valid; returns latency from the capture edge.
    task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] ex,
                          input logic [W-1:0] md, output int cycles);
        @(negedge clk);
        base    = b;
        e       = ex;
        n       = md;
        e_valid = 1'b1;
        @(posedge clk);
        wait_done(20000, cycles);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        e_valid  = 1'b0;
        e        = '0;
        n        = '0;
        base     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_error", {63'd0, error}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // 2^10 mod 1000 = 24; latency 1+66+61+(133+67+133+67) = 528
        run_op(64'd2, 64'd10, 64'd1000, lat);
        check("e10_result", result, 64'd24);
        check("e10_done", {63'd0, done}, 64'd1);
        check("e10_error", {63'd0, error}, 64'd0);
        check("e10_latency", 64'(lat), 64'd528);

        // After done: e_valid toggled and e changed must not re-arm
        @(negedge clk);
        e_valid = 1'b0;
        repeat (3) @(negedge clk);
        e       = 64'd3;
        base    = 64'd5;
        e_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("hold_result", result, 64'd24);
        check("hold_done", {63'd0, done}, 64'd1);

        // 100 mod 7 = 2, e=1
        apply_reset();
        run_op(64'd100, 64'd1, 64'd7, lat);
        check("reduce_result", result, 64'd2);
        check("reduce_done", {63'd0, done}, 64'd1);

        // e=0: result 1, only CHECK + REDUCE + 64 SKIP cycles
        apply_reset();
        run_op(64'd2, 64'd0, 64'd97, lat);
        check("e0_result", result, 64'd1);
        check("e0_latency", 64'(lat), 64'd131);

        // 2^(2^64-1) mod 3 = 2 (odd power of -1)
        apply_reset();
        run_op(64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, lat);
        check("ones_result", result, 64'd2);
        check("ones_done", {63'd0, done}, 64'd1);

        // n=1: result 0, no error, done right after CHECK
        apply_reset();
        run_op(64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, lat);
        check("n1_result", result, 64'd0);
        check("n1_error", {63'd0, error}, 64'd0);
        check("n1_latency", 64'(lat), 64'd1);

        // n=0: result 0 with error
        apply_reset();
        run_op(64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, lat);
        check("n0_result", result, 64'd0);
        check("n0_error", {63'd0, error}, 64'd1);
        check("n0_done", {63'd0, done}, 64'd1);

        // Reset in the middle of the first SQR (entered ~129 edges after
        // capture, lasting 66), e_valid held high -> fresh capture.
        apply_reset();
        @(negedge clk);
        base    = 64'd3;
        e       = 64'd5;
        n       = 64'd11;
        e_valid = 1'b1;
        repeat (150) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_result", result, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_error", {63'd0, error}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_done(20000, lat);
        check("recap_result", result, 64'd1);
        check("recap_done", {63'd0, done}, 64'd1);
        check("recap_error", {63'd0, error}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
